// File: rtl/wptr_full_status_if.sv
// Write-side bus of the dual-clock FIFO write pointer / status block.
//   master : producer + rptr->wclk synchronizer side (drives winc, wq2_rptr, wovf_clr)
//   slave  : wptr_full_status (drives write enable, address, Gray pointer, status)
// Signals:
//   winc         write request
//   wq2_rptr     Gray read pointer already synchronized into wclk
//   wovf_clr     clear for the sticky overflow flag
//   wclken       memory write enable (combinational)
//   waddr        memory write address
//   wptr         registered Gray write pointer
//   wfull        registered full flag
//   walmost_full registered almost-full flag
//   wlevel       registered fill estimate, 0..DEPTH
//   woverflow    sticky "write attempted while full"
interface wptr_full_status_if #(
  parameter int ADDRSIZE = 4
);
  logic                winc;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic                wovf_clr;
  logic                wclken;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wlevel;
  logic                woverflow;

  modport master (
    output winc, wq2_rptr, wovf_clr,
    input  wclken, waddr, wptr, wfull, walmost_full, wlevel, woverflow
  );

  modport slave (
    input  winc, wq2_rptr, wovf_clr,
    output wclken, waddr, wptr, wfull, walmost_full, wlevel, woverflow
  );
endinterface

// File: rtl/wptr_full_status.sv
// Write-domain pointer and status generator for the dual-clock FIFO.
// Holds the binary write address and registered Gray write pointer, and
// derives full / almost-full / fill level against the read pointer that has
// been synchronized into wclk. A sticky overflow flag records writes that
// were refused because the FIFO was full.
// Ports:
//   wclk    write clock, all state on the rising edge
//   wrst_n  asynchronous active-low reset
//   bus     wptr_full_status_if.slave (see interface for signal list)
// Status is pessimistic: wq2_rptr lags the real read pointer, so full,
// almost-full and level may over-report but never under-report.
module wptr_full_status #(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  wptr_full_status_if.slave     bus
);
  localparam int              DEPTH     = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] AFULL_LVL = (ADDRSIZE+1)'(DEPTH - AFULL_MARGIN);

  logic [ADDRSIZE:0] wbin, wbinnext, wgraynext, rq2bin, lvlnext;
  logic [ADDRSIZE:0] wptr_q, wlevel_q;
  logic              wfull_q, wafull_q, wovf_q;
  logic              accept, full_next, afull_next, ovf_set;

  assign accept    = bus.winc & ~wfull_q;
  assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, accept};
  assign wgraynext = (wbinnext >> 1) ^ wbinnext;

  // Gray -> binary: each bit is the XOR of itself and all higher bits.
  always_comb begin
    rq2bin = '0;
    for (int i = 0; i <= ADDRSIZE; i++)
      rq2bin[i] = ^(bus.wq2_rptr >> i);
  end

  // Modulo subtract keeps the level right across pointer wrap.
  assign lvlnext    = wbinnext - rq2bin;
  assign afull_next = (lvlnext >= AFULL_LVL);

  // Full when write pointer is one lap ahead: top two Gray bits inverted,
  // the rest equal.
  assign full_next = (wgraynext == {~bus.wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                                     bus.wq2_rptr[ADDRSIZE-2:0]});

  assign ovf_set = bus.winc & wfull_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin     <= '0;
      wptr_q   <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wlevel_q <= '0;
      wovf_q   <= 1'b0;
    end else begin
      wbin     <= wbinnext;
      wptr_q   <= wgraynext;
      wfull_q  <= full_next;
      wafull_q <= afull_next;
      wlevel_q <= lvlnext;
      // A new refused write beats a simultaneous clear.
      wovf_q   <= ovf_set | (wovf_q & ~bus.wovf_clr);
    end
  end

  assign bus.wclken       = accept;
  assign bus.waddr        = wbin[ADDRSIZE-1:0];
  assign bus.wptr         = wptr_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = wafull_q;
  assign bus.wlevel       = wlevel_q;
  assign bus.woverflow    = wovf_q;
endmodule
